// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and boundary indices for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } hz_state_t;

  localparam int FWD_NONE   = 0;
  localparam int ECODE_W    = 15;

  // pipeline-register boundaries: IF1/IF2, IF2/ID, ID/EX, EX/MM1 ...
  localparam int PR_IF1_IF2 = 0;
  localparam int PR_IF2_ID  = 1;
  localparam int PR_ID_EX   = 2;
  localparam int PR_EX_MM1  = 3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - one decode operand against all producing stages
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int NSTG     = 4,
  parameter int RW       = 5,
  parameter int SW       = 3,
  parameter int LOAD_LAT = 2
) (
  input  logic               ren,
  input  logic [RW-1:0]      src,
  input  logic [NSTG-1:0]    stg_wen,
  input  logic [NSTG-1:0]    stg_load,
  input  logic [NSTG*RW-1:0] stg_reg,
  output logic [SW-1:0]      sel,
  output logic               mem,
  output logic               lau
);

  // Walk from the oldest stage to the youngest so the lowest index wins.
  always_comb begin
    sel = SW'(FWD_NONE);
    mem = 1'b0;
    lau = 1'b0;
    if (ren && src != '0) begin
      for (int i = NSTG - 1; i >= 0; i--) begin
        if (stg_wen[i] && stg_reg[i*RW +: RW] == src) begin
          sel = SW'(i + 1);
          mem = stg_load[i] && (i == LOAD_LAT);
          lau = stg_load[i] && (i < LOAD_LAT);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// rtl/hazard_ctrl_sb.sv - forwarding, scoreboard stalls, redirects and exception drain
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NSRC     = 3,
  parameter int NSTG     = 4,
  parameter int LOAD_LAT = 2,
  parameter int XLEN     = 32,
  localparam int RW      = $clog2(NREG),
  localparam int SW      = $clog2(NSTG + 1),
  localparam int NPR     = NSTG + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NSRC-1:0]      id_src_ren,
  input  logic [NSRC*RW-1:0]   id_src_reg,
  input  logic                 id_dst_wen,
  input  logic [RW-1:0]        id_dst_reg,
  input  logic                 id_long,
  input  logic [XLEN-1:0]      id_pc,
  input  logic                 id_is_branch,
  input  logic                 id_branch_bp,
  input  logic                 id_ine,
  input  logic [ECODE_W-1:0]   id_ecode,
  input  logic [NSTG-1:0]      stg_wen,
  input  logic [NSTG-1:0]      stg_load,
  input  logic [NSTG*RW-1:0]   stg_reg,
  input  logic                 ex_out_valid,
  input  logic                 ex_branch,
  input  logic                 ex_branch_bp,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_pc_branch,
  input  logic                 long_done,
  input  logic [RW-1:0]        long_done_reg,
  input  logic                 trap_ack,
  input  logic [XLEN-1:0]      trap_entry,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic [NSRC-1:0]      fwd_mem,
  output logic [NPR-1:0]       pr_wen,
  output logic [NPR-1:0]       pr_flush,
  output logic                 id_ex_bp_flush,
  output logic                 pc_wen,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 trap_valid,
  output logic [XLEN-1:0]      trap_pc,
  output logic [ECODE_W-1:0]   trap_ecode,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_flush
);

  logic [NSRC-1:0] src_lau;
  logic            lau;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    hazard_src_match #(
      .NSTG(NSTG), .RW(RW), .SW(SW), .LOAD_LAT(LOAD_LAT)
    ) u_match (
      .ren      (id_src_ren[g]),
      .src      (id_src_reg[g*RW +: RW]),
      .stg_wen  (stg_wen),
      .stg_load (stg_load),
      .stg_reg  (stg_reg),
      .sel      (fwd_sel[g*SW +: SW]),
      .mem      (fwd_mem[g]),
      .lau      (src_lau[g])
    );
  end

  assign lau = |src_lau;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            sb_stall;
  logic            id_fire;
  logic            bp_fault;

  always_comb begin
    sb_stall = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (id_src_ren[s] && pending[id_src_reg[s*RW +: RW]]) sb_stall = 1'b1;
    end
    if (id_dst_wen && pending[id_dst_reg]) sb_stall = 1'b1;
    sb_stall = sb_stall && id_valid;
  end

  assign bp_fault = (ex_branch != ex_branch_bp) || (ex_branch && ex_pc_branch != id_pc);

  hz_state_t state, state_nxt;
  logic      capture;
  logic      freeze;

  always_comb begin
    state_nxt      = state;
    pr_wen         = '1;
    pr_flush       = '0;
    pc_wen         = 1'b1;
    id_ex_bp_flush = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap_valid     = 1'b0;
    capture        = 1'b0;
    freeze         = 1'b0;
    if (rst) begin
      state_nxt = ST_RUN;
      pr_wen    = '0;
      pr_flush  = '1;
      pc_wen    = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!ex_out_valid) begin
            pr_wen[PR_ID_EX:PR_IF1_IF2] = '0;
            pr_flush[PR_EX_MM1]         = 1'b1;
            pc_wen                      = 1'b0;
            freeze                      = 1'b1;
          end else if (bp_fault) begin
            redirect_valid                = 1'b1;
            redirect_pc                   = ex_branch ? ex_pc_branch : ex_pc + XLEN'(4);
            pr_flush[PR_ID_EX:PR_IF1_IF2] = '1;
          end else if (id_ine) begin
            pr_flush[PR_ID_EX:PR_IF1_IF2] = '1;
            pc_wen                        = 1'b0;
            capture                       = 1'b1;
            state_nxt                     = ST_DRAIN;
          end else if (lau || sb_stall) begin
            pr_wen[PR_IF2_ID:PR_IF1_IF2] = '0;
            pr_flush[PR_ID_EX]           = 1'b1;
            pc_wen                       = 1'b0;
            freeze                       = 1'b1;
          end else if (!id_is_branch && id_branch_bp) begin
            redirect_valid                 = 1'b1;
            redirect_pc                    = id_pc + XLEN'(4);
            pr_flush[PR_IF2_ID:PR_IF1_IF2] = '1;
            id_ex_bp_flush                 = 1'b1;
          end
        end
        ST_DRAIN: begin
          pr_wen[PR_IF2_ID:PR_IF1_IF2] = '0;
          pr_flush[PR_ID_EX]           = 1'b1;
          pc_wen                       = 1'b0;
          if (stg_wen == '0 && pending == '0) state_nxt = ST_TRAP;
        end
        ST_TRAP: begin
          trap_valid                   = 1'b1;
          pr_wen[PR_IF2_ID:PR_IF1_IF2] = '0;
          pr_flush[PR_ID_EX]           = 1'b1;
          pc_wen                       = 1'b0;
          if (trap_ack) begin
            redirect_valid                 = 1'b1;
            redirect_pc                    = trap_entry;
            pr_wen[PR_IF2_ID:PR_IF1_IF2]   = '1;
            pr_flush[PR_IF2_ID:PR_IF1_IF2] = '1;
            pc_wen                         = 1'b1;
            state_nxt                      = ST_RUN;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign id_fire = id_valid && id_long && id_dst_wen && pr_wen[PR_ID_EX] && !pr_flush[PR_ID_EX];

  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (long_done) pending_nxt[long_done_reg] = 1'b0;
    if (id_fire && id_dst_reg != '0) pending_nxt[id_dst_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pending    <= '0;
      trap_pc    <= '0;
      trap_ecode <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (capture) begin
        trap_pc    <= id_pc;
        trap_ecode <= id_ecode;
      end
      if (freeze) perf_stall <= sat_inc(perf_stall);
      if (redirect_valid) perf_flush <= sat_inc(perf_flush);
    end
  end

endmodule
